// File: rtl/alu_pkg.sv
// Shared definitions for the wide ALU sequencer: alu op-field bit positions, FSM states, sizing helper.
// No logic; no latency; no flow control.
package alu_pkg;

    localparam int OP_ARITH = 3;
    localparam int OP_SHIFT = 2;
    localparam int OP_SUB   = 1;
    localparam int OP_CARRY = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Index width that never collapses to zero bits for a single-byte operand.
    function automatic int clog2_min1(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < n) r++;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/byte_lane_mux.sv
// Selects one byte lane out of an NBYTES-wide word by index.
// Purely combinational, zero latency; no flow control.
module byte_lane_mux #(
    parameter int NBYTES = 2,
    parameter int IDXW   = 1
) (
    input  logic [8*NBYTES-1:0] d,
    input  logic [IDXW-1:0]     sel,
    output logic [7:0]          q
);

    always_comb begin
        q = '0;
        for (int i = 0; i < NBYTES; i++) begin
            if (sel == IDXW'(i)) q = d[i*8 +: 8];
        end
    end

endmodule

// File: rtl/wide_alu_seq.sv
// Sequences an NBYTES-wide operation through an 8-bit combinational alu, one byte per cycle, chaining carry.
// Latency: request accepted at edge k -> rsp_valid from edge k+NBYTES; request-to-request period NBYTES+2.
// Backpressure: rsp_ready low holds DONE with outputs frozen; req_ready stays low until the response is taken.
module wide_alu_seq
    import alu_pkg::*;
#(
    parameter  int NBYTES = 2,
    localparam int IDXW   = clog2_min1(NBYTES)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [8*NBYTES-1:0] req_a,
    input  logic [8*NBYTES-1:0] req_b,
    input  logic [3:0]          req_op,
    input  logic                req_xy,
    input  logic                req_cin,
    input  logic                req_msb_first,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [8*NBYTES-1:0] rsp_q,
    output logic                rsp_cout,
    output logic [7:0]          alu_a,
    output logic [7:0]          alu_b,
    output logic [3:0]          alu_op,
    output logic                alu_xy,
    output logic                alu_cin,
    input  logic [7:0]          alu_q,
    input  logic                alu_cout
);

    state_t              state;
    logic [IDXW-1:0]     idx;
    logic [IDXW-1:0]     cnt;
    logic                carry;
    logic [8*NBYTES-1:0] a_reg;
    logic [8*NBYTES-1:0] b_reg;
    logic [8*NBYTES-1:0] res_reg;
    logic [3:0]          op_reg;
    logic                xy_reg;
    logic                cin_reg;
    logic                msb_reg;
    logic                rdy_reg;
    logic                vld_reg;

    logic [7:0]          a_byte;
    logic [7:0]          b_byte;
    logic                first_byte;

    byte_lane_mux #(.NBYTES(NBYTES), .IDXW(IDXW)) u_mux_a (
        .d   (a_reg),
        .sel (idx),
        .q   (a_byte)
    );

    byte_lane_mux #(.NBYTES(NBYTES), .IDXW(IDXW)) u_mux_b (
        .d   (b_reg),
        .sel (idx),
        .q   (b_byte)
    );

    assign first_byte = (cnt == '0);

    always_comb begin
        alu_a   = '0;
        alu_b   = '0;
        alu_op  = '0;
        alu_xy  = 1'b0;
        alu_cin = 1'b0;
        if (state == RUN) begin
            alu_a   = a_byte;
            alu_b   = b_byte;
            alu_xy  = xy_reg;
            alu_cin = first_byte ? cin_reg : carry;
            alu_op  = op_reg;
            // Upper bytes of add/sub must consume the chained carry/borrow.
            if (!first_byte && op_reg[OP_ARITH] && !op_reg[OP_SHIFT])
                alu_op[OP_CARRY] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            idx     <= '0;
            cnt     <= '0;
            carry   <= 1'b0;
            a_reg   <= '0;
            b_reg   <= '0;
            res_reg <= '0;
            op_reg  <= '0;
            xy_reg  <= 1'b0;
            cin_reg <= 1'b0;
            msb_reg <= 1'b0;
            rdy_reg <= 1'b0;
            vld_reg <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    rdy_reg <= 1'b1;
                    if (req_valid && rdy_reg) begin
                        a_reg   <= req_a;
                        b_reg   <= req_b;
                        op_reg  <= req_op;
                        xy_reg  <= req_xy;
                        cin_reg <= req_cin;
                        msb_reg <= req_msb_first;
                        idx     <= req_msb_first ? IDXW'(NBYTES - 1) : '0;
                        cnt     <= '0;
                        rdy_reg <= 1'b0;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    for (int i = 0; i < NBYTES; i++) begin
                        if (idx == IDXW'(i)) res_reg[i*8 +: 8] <= alu_q;
                    end
                    carry <= alu_cout;
                    cnt   <= cnt + 1'b1;
                    idx   <= msb_reg ? idx - 1'b1 : idx + 1'b1;
                    if (cnt == IDXW'(NBYTES - 1)) begin
                        state   <= DONE;
                        vld_reg <= 1'b1;
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        state   <= IDLE;
                        vld_reg <= 1'b0;
                        rdy_reg <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign req_ready = rdy_reg;
    assign rsp_valid = vld_reg;
    assign rsp_q     = res_reg;
    assign rsp_cout  = carry;

endmodule

// File: tb/tb_wide_alu_seq.sv
// Directed bench for wide_alu_seq (NBYTES=2) wired to a small behavioural 8-bit alu.
// Checks per-byte alu drive, assembled result, latency, backpressure and mid-run reset.
module tb_wide_alu_seq;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic [3:0]  req_op;
    logic        req_xy;
    logic        req_cin;
    logic        req_msb_first;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_q;
    logic        rsp_cout;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [3:0]  alu_op;
    logic        alu_xy;
    logic        alu_cin;
    logic [7:0]  alu_q;
    logic        alu_cout;

    int n_tests = 0;
    int n_fail  = 0;

    wide_alu_seq #(.NBYTES(2)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_a         (req_a),
        .req_b         (req_b),
        .req_op        (req_op),
        .req_xy        (req_xy),
        .req_cin       (req_cin),
        .req_msb_first (req_msb_first),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_q         (rsp_q),
        .rsp_cout      (rsp_cout),
        .alu_a         (alu_a),
        .alu_b         (alu_b),
        .alu_op        (alu_op),
        .alu_xy        (alu_xy),
        .alu_cin       (alu_cin),
        .alu_q         (alu_q),
        .alu_cout      (alu_cout)
    );

    // Reference alu: 10xc add/sub (cin used only when c=1, cout is carry/borrow),
    // x1xx shift (xy=1 right, xy=0 left, cin shifted in), 00xx bitwise.
    logic [8:0] alu_sum;
    always_comb begin
        alu_sum  = '0;
        alu_q    = '0;
        alu_cout = 1'b0;
        if (alu_op[3:2] == 2'b10) begin
            if (alu_op[1])
                alu_sum = {1'b0, alu_a} - {1'b0, alu_b} - {8'd0, alu_op[0] & alu_cin};
            else
                alu_sum = {1'b0, alu_a} + {1'b0, alu_b} + {8'd0, alu_op[0] & alu_cin};
            alu_q    = alu_sum[7:0];
            alu_cout = alu_sum[8];
        end else if (alu_op[2]) begin
            if (alu_xy) begin
                alu_q    = {alu_cin, alu_a[7:1]};
                alu_cout = alu_a[0];
            end else begin
                alu_q    = {alu_a[6:0], alu_cin};
                alu_cout = alu_a[7];
            end
        end else begin
            case (alu_op[1:0])
                2'b00:   alu_q = alu_a & alu_b;
                2'b01:   alu_q = alu_a | alu_b;
                2'b10:   alu_q = alu_a ^ alu_b;
                default: alu_q = ~alu_a;
            endcase
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_ready(input string tag);
        for (int i = 0; i < 20; i++) begin
            if (req_ready === 1'b1) break;
            @(negedge clk);
        end
        check({tag, "_ready_timeout"}, req_ready, 1'b1);
    endtask

    // Entered and left at a negedge.
    task automatic do_op(input string tag,
                         input logic [15:0] a, input logic [15:0] b, input logic [3:0] op,
                         input logic xy, input logic cin, input logic msb,
                         input logic [3:0] eop0, input logic [3:0] eop1,
                         input logic ecin0, input logic ecin1,
                         input logic [7:0] ea0, input logic [7:0] ea1,
                         input logic [15:0] eq, input logic ecout, input int hold);
        wait_ready(tag);
        req_valid = 1'b1; req_a = a; req_b = b; req_op = op;
        req_xy = xy; req_cin = cin; req_msb_first = msb;
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_a = 16'hDEAD; req_b = 16'hBEEF; req_op = 4'hF;
        req_cin = ~cin; req_msb_first = ~msb;
        @(negedge clk);
        check({tag, "_op0"},  alu_op,  eop0);
        check({tag, "_cin0"}, alu_cin, ecin0);
        check({tag, "_a0"},   alu_a,   ea0);
        check({tag, "_xy0"},  alu_xy,  xy);
        check({tag, "_vld0"}, rsp_valid, 1'b0);
        check({tag, "_rdy0"}, req_ready, 1'b0);
        @(negedge clk);
        check({tag, "_op1"},  alu_op,  eop1);
        check({tag, "_cin1"}, alu_cin, ecin1);
        check({tag, "_a1"},   alu_a,   ea1);
        check({tag, "_vld1"}, rsp_valid, 1'b0);
        @(negedge clk);
        check({tag, "_vld"},  rsp_valid, 1'b1);
        check({tag, "_q"},    rsp_q,     eq);
        check({tag, "_cout"}, rsp_cout,  ecout);
        check({tag, "_alu_idle"}, {alu_a, alu_op}, 12'h0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, "_hold_vld"}, rsp_valid, 1'b1);
            check({tag, "_hold_q"},   rsp_q,     eq);
            check({tag, "_hold_cout"}, rsp_cout, ecout);
            check({tag, "_hold_rdy"}, req_ready, 1'b0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check({tag, "_vld_drop"}, rsp_valid, 1'b0);
        check({tag, "_rdy_back"}, req_ready, 1'b1);
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
        req_a = '0; req_b = '0; req_op = '0; req_xy = 1'b0; req_cin = 1'b0; req_msb_first = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ready", req_ready, 1'b0);
        check("rst_vld",   rsp_valid, 1'b0);
        check("rst_q",     rsp_q,     16'h0);
        check("rst_cout",  rsp_cout,  1'b0);
        check("rst_alu",   {alu_a, alu_b, alu_op, alu_xy, alu_cin}, 22'h0);
        rst_n = 1'b1;
        check("post_rst_ready_low", req_ready, 1'b0);
        @(negedge clk);
        check("post_rst_ready", req_ready, 1'b1);

        //     tag        a        b        op       xy    cin   msb   op0      op1      c0    c1    a0     a1     q        cout  hold
        do_op("add",     16'h12FF, 16'h0001, 4'b1000, 1'b0, 1'b0, 1'b0, 4'b1000, 4'b1001, 1'b0, 1'b1, 8'hFF, 8'h12, 16'h1300, 1'b0, 0);
        do_op("add_wrap", 16'hFFFF, 16'h0001, 4'b1000, 1'b0, 1'b0, 1'b0, 4'b1000, 4'b1001, 1'b0, 1'b1, 8'hFF, 8'hFF, 16'h0000, 1'b1, 0);
        do_op("sub",     16'h1300, 16'h0001, 4'b1010, 1'b0, 1'b0, 1'b0, 4'b1010, 4'b1011, 1'b0, 1'b1, 8'h00, 8'h13, 16'h12FF, 1'b0, 0);
        do_op("and",     16'hF0F0, 16'hFF00, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 8'hF0, 8'hF0, 16'hF000, 1'b0, 0);
        do_op("adc_cin", 16'h00FF, 16'h0000, 4'b1001, 1'b0, 1'b1, 1'b0, 4'b1001, 4'b1001, 1'b1, 1'b1, 8'hFF, 8'h00, 16'h0100, 1'b0, 0);
        do_op("shr_msb", 16'h8001, 16'h0000, 4'b0100, 1'b1, 1'b0, 1'b1, 4'b0100, 4'b0100, 1'b0, 1'b0, 8'h80, 8'h01, 16'h4000, 1'b1, 0);
        do_op("bp",      16'h12FF, 16'h0001, 4'b1000, 1'b0, 1'b0, 1'b0, 4'b1000, 4'b1001, 1'b0, 1'b1, 8'hFF, 8'h12, 16'h1300, 1'b0, 5);

        // Reset in the middle of an operation discards it.
        wait_ready("mid_rst");
        req_valid = 1'b1; req_a = 16'h12FF; req_b = 16'h0001; req_op = 4'b1000;
        req_xy = 1'b0; req_cin = 1'b0; req_msb_first = 1'b0;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        check("mid_rst_running", alu_a, 8'hFF);
        rst_n = 1'b0;
        #1;
        check("mid_rst_vld",   rsp_valid, 1'b0);
        check("mid_rst_ready", req_ready, 1'b0);
        check("mid_rst_q",     rsp_q,     16'h0);
        check("mid_rst_cout",  rsp_cout,  1'b0);
        check("mid_rst_alu",   {alu_a, alu_b, alu_op, alu_xy, alu_cin}, 22'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("mid_rst_no_rsp", rsp_valid, 1'b0);
        end
        check("mid_rst_ready_after", req_ready, 1'b1);

        do_op("after_rst", 16'h1300, 16'h0001, 4'b1010, 1'b0, 1'b0, 1'b0, 4'b1010, 4'b1011, 1'b0, 1'b1, 8'h00, 8'h13, 16'h12FF, 1'b0, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
